// File: rtl/zap_fifo_pkg.sv
// Shared types and helpers for the FWFT FIFO family.
package zap_fifo_pkg;

  // Head register plus one skid register behind the RAM read port.
  localparam int OUT_STAGE_DEPTH = 2;

  // Occupancy of the output stage: 0, 1 or 2.
  typedef logic [1:0] out_occ_t;

  // Count width: enough bits to hold the value DEPTH itself.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/zap_ram_simple_nopipe.sv
// 1R+1W block RAM with a single registered read stage.
// A read and a write to the same address in one cycle return the new data.
module zap_ram_simple_nopipe #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
  end

  // Registered read port with write-first bypass on address collision.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      if (i_wr_en && (i_wr_addr == i_rd_addr)) rd_data_q <= i_wr_data;
      else                                     rd_data_q <= mem_q[i_rd_addr];
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/zap_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO on a 1-cycle-read block RAM.
// A 2-entry output stage (head + skid) hides the RAM read latency so that
// one push and one pop per cycle can be sustained.
// Optional macro ZAP_SYNC_FIFO_BYPASS_EN: a push into an empty FIFO goes
// straight to the head register, giving 1-cycle latency instead of 3.
module zap_sync_fifo_fwft
  import zap_fifo_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int CW    = fifo_cw(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic [CW-1:0]    o_count
);

  logic [CW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    rptr_q, rptr_d;
  logic             pend_q, pend_d;
  out_occ_t         out_occ_q, out_occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic [CW-1:0]    mem_cnt;
  logic [CW-1:0]    count;
  logic [2:0]       stage_load;
  logic             push, pop, bypass, ram_we, issue;
  logic [WIDTH-1:0] ram_rd_data;

  // Occupancy is tracked by counting, never by comparing pointers.
  assign mem_cnt    = wptr_q - rptr_q;
  assign count      = mem_cnt + CW'(pend_q) + CW'(out_occ_q);
  assign o_count    = count;
  assign o_full     = (count == CW'(DEPTH));
  assign o_rd_valid = (out_occ_q != '0);
  assign o_rd_data  = head_q;

  assign push = i_wr_en & ~o_full;
  assign pop  = i_rd_en & o_rd_valid;

`ifdef ZAP_SYNC_FIFO_BYPASS_EN
  assign bypass = push & (count == '0) & ~i_clear;
`else
  assign bypass = 1'b0;
`endif

  assign ram_we = push & ~bypass & ~i_clear;

  // Entries the output stage will hold once the in-flight read lands and
  // this cycle's pop leaves; only read when there is room for the result.
  assign stage_load = {1'b0, out_occ_q} + {2'b00, pend_q} - {2'b00, pop};
  assign issue      = (mem_cnt != '0) && (stage_load < 3'(OUT_STAGE_DEPTH)) && ~i_clear;

  zap_ram_simple_nopipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (ram_we),
    .i_wr_addr (wptr_q[CW-2:0]),
    .i_wr_data (i_wr_data),
    .i_rd_en   (issue),
    .i_rd_addr (rptr_q[CW-2:0]),
    .o_rd_data (ram_rd_data)
  );

  // Pointer and read-pending next state; clear wins over everything.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    pend_d = issue;
    if (ram_we) wptr_d = wptr_q + CW'(1);
    if (issue)  rptr_d = rptr_q + CW'(1);
    if (i_clear) begin
      wptr_d = '0;
      rptr_d = '0;
      pend_d = 1'b0;
    end
  end

  // Output stage: pop shifts skid to head, RAM return fills the first free slot.
  always_comb begin
    head_d    = head_q;
    skid_d    = skid_q;
    out_occ_d = out_occ_q;
    if (i_clear) begin
      out_occ_d = '0;
    end else begin
      if (pop) begin
        head_d    = skid_q;
        out_occ_d = out_occ_q - 2'd1;
      end
      if (pend_q) begin
        if (out_occ_d == '0) head_d = ram_rd_data;
        else                 skid_d = ram_rd_data;
        out_occ_d = out_occ_d + 2'd1;
      end
      if (bypass) begin
        head_d    = i_wr_data;
        out_occ_d = 2'd1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      pend_q    <= 1'b0;
      out_occ_q <= '0;
      head_q    <= '0;
      skid_q    <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      pend_q    <= pend_d;
      out_occ_q <= out_occ_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
    end
  end

endmodule
